// File: rtl/zone_alarm_pkg.sv
// Shared types and constants for the zone alarm engine: one-hot FSM encoding,
// disabled-boundary marker and saturation limits.
package zone_alarm_pkg;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ARM    = 5'b00010,
        S_READ   = 5'b00100,
        S_CMP    = 5'b01000,
        S_FINISH = 5'b10000
    } state_t;

    // Sliced down to DW by the user; an all-ones boundary disables a point.
    localparam logic [63:0] BOUND_DISABLED = '1;
    localparam logic [7:0]  RUN_MAX        = 8'd255;
    localparam logic [3:0]  STREAK_MAX     = 4'd15;

    // A programmed threshold of zero behaves as one.
    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/zone_tracker.sv
// Per-zone hit-run, scan-hit flag, hit/clear streaks and alarm state.
// ZONE_FAST_ALARM_EN: raise the alarm as soon as the scan-hit flag sets (assert_cnt<=1).
module zone_tracker
    import zone_alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cmp_fire,
    input  logic       hit,
    input  logic       scan_update,
    input  logic [7:0] min_pts,
    input  logic [3:0] assert_cnt,
    input  logic [3:0] clear_cnt,
    output logic       alarm
);

    logic [7:0] run, run_nxt;
    logic       scan_hit;
    logic [3:0] hit_streak, clear_streak, hs_nxt, cs_nxt;

    always_comb begin
        run_nxt = '0;
        if (hit)
            run_nxt = (run == RUN_MAX) ? run : run + 8'd1;
        hs_nxt = (hit_streak == STREAK_MAX) ? hit_streak : hit_streak + 4'd1;
        cs_nxt = (clear_streak == STREAK_MAX) ? clear_streak : clear_streak + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run          <= '0;
            scan_hit     <= 1'b0;
            hit_streak   <= '0;
            clear_streak <= '0;
            alarm        <= 1'b0;
        end else begin
            if (clr) begin
                run      <= '0;
                scan_hit <= 1'b0;
            end else if (cmp_fire) begin
                run <= run_nxt;
                if (hit && run_nxt >= at_least_one(min_pts))
                    scan_hit <= 1'b1;
            end

            if (scan_update) begin
                if (scan_hit) begin
                    hit_streak   <= hs_nxt;
                    clear_streak <= '0;
                    if ({4'b0, hs_nxt} >= at_least_one({4'b0, assert_cnt}))
                        alarm <= 1'b1;
                end else begin
                    clear_streak <= cs_nxt;
                    hit_streak   <= '0;
                    if ({4'b0, cs_nxt} >= at_least_one({4'b0, clear_cnt}))
                        alarm <= 1'b0;
                end
            end
`ifdef ZONE_FAST_ALARM_EN
            else if (scan_hit && assert_cnt <= 4'd1) begin
                alarm <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/zone_alarm_engine.sv
// Scan-based safety zone alarm: compares each angular sample against per-zone
// boundaries read from RAM. Optional macro ZONE_FAST_ALARM_EN (see zone_tracker).
module zone_alarm_engine
    import zone_alarm_pkg::*;
#(
    parameter int NZONE  = 3,
    parameter int NPOINT = 811,
    parameter int DW     = 16,
    parameter int AW     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          hw_type,
    input  logic                cycle_enable,
    input  logic                target_valid,
    input  logic [DW-1:0]       target_pos,
    input  logic [7:0]          min_target_pts,
    input  logic [3:0]          assert_cnt,
    input  logic [3:0]          clear_cnt,
    output logic                zone_rden,
    output logic [AW-1:0]       zone_rdaddr,
    input  logic [NZONE*DW-1:0] zone_rddata,
    output logic [NZONE-1:0]    alarm_io,
    output logic                scan_done,
    output logic                scan_overrun
);

    localparam int PW = $clog2(NPOINT + 1);

    state_t                    state, state_nxt;
    logic                      ce_q1, ce_q2, rise, fall, fall_pend, done;
    logic                      rd_q, go_read, in_range;
    logic                      st_arm, st_read, st_finish, st_wait;
    logic [PW-1:0]             pt_idx, pt_nxt;
    logic [DW-1:0]             pos_q;
    logic [NZONE-1:0][DW-1:0]  bound;
    logic [NZONE-1:0]          hit, alarm_r;

    assign rise  = ce_q1 & ~ce_q2;
    assign fall  = ~ce_q1 & ce_q2;
    assign done  = fall | fall_pend;
    assign bound = zone_rddata;

    // The compare of the previous sample retires in the same cycle a new one may arrive.
    always_comb begin
        pt_nxt = pt_idx;
        if (st_arm)
            pt_nxt = '0;
        else if (rd_q)
            pt_nxt = pt_idx + PW'(1);
    end

    assign in_range = (pt_nxt < PW'(NPOINT));
    assign go_read  = st_wait & ~done & target_valid & in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:       if (rise) state_nxt = S_ARM;
            S_ARM, S_CMP: begin
                if (done)         state_nxt = S_FINISH;
                else if (go_read) state_nxt = S_READ;
            end
            S_READ:       state_nxt = S_CMP;
            S_FINISH:     state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        st_arm    = (state == S_ARM);
        st_read   = (state == S_READ);
        st_finish = (state == S_FINISH);
        st_wait   = (state == S_ARM) || (state == S_CMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q1        <= 1'b0;
            ce_q2        <= 1'b0;
            fall_pend    <= 1'b0;
            rd_q         <= 1'b0;
            pt_idx       <= '0;
            pos_q        <= '0;
            zone_rden    <= 1'b0;
            zone_rdaddr  <= '0;
            scan_overrun <= 1'b0;
            scan_done    <= 1'b0;
            alarm_io     <= '0;
        end else begin
            ce_q1  <= cycle_enable;
            ce_q2  <= ce_q1;
            rd_q   <= st_read;
            pt_idx <= pt_nxt;
            // A fall seen while in READ is held until the FSM can act on it.
            if (state == S_IDLE || st_finish) fall_pend <= 1'b0;
            else if (fall)                    fall_pend <= 1'b1;
            zone_rden <= go_read;
            if (go_read) begin
                zone_rdaddr <= AW'(pt_nxt);
                pos_q       <= target_pos;
            end
            if (st_arm)                       scan_overrun <= 1'b0;
            else if (st_read && target_valid) scan_overrun <= 1'b1;
            scan_done <= st_finish;
            alarm_io  <= (hw_type == 2'd1) ? ~alarm_r : alarm_r;
        end
    end

    for (genvar z = 0; z < NZONE; z++) begin : g_zone
        assign hit[z] = (bound[z] != BOUND_DISABLED[DW-1:0]) &&
                        (pos_q != '0) && (pos_q <= bound[z]);

        zone_tracker u_trk (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr         (st_arm),
            .cmp_fire    (rd_q),
            .hit         (hit[z]),
            .scan_update (st_finish),
            .min_pts     (min_target_pts),
            .assert_cnt  (assert_cnt),
            .clear_cnt   (clear_cnt),
            .alarm       (alarm_r[z])
        );
    end

endmodule

// File: tb/tb_zone_alarm_engine.sv
// Directed bench for zone_alarm_engine with a registered boundary-RAM model.
module tb_zone_alarm_engine;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        hw_type;
    logic              cycle_enable;
    logic              target_valid;
    logic [15:0]       target_pos;
    logic [7:0]        min_target_pts;
    logic [3:0]        assert_cnt;
    logic [3:0]        clear_cnt;
    logic              zone_rden;
    logic [9:0]        zone_rdaddr;
    logic [47:0]       zone_rddata;
    logic [2:0]        alarm_io;
    logic              scan_done;
    logic              scan_overrun;

    logic [2:0][15:0]  bnd;
    int                n_cmp = 0, n_err = 0;
    int                nreads = 0, last_addr = -1, n0;
    logic [9:0]        last_rd;

    always #5 clk = ~clk;

    zone_alarm_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hw_type        (hw_type),
        .cycle_enable   (cycle_enable),
        .target_valid   (target_valid),
        .target_pos     (target_pos),
        .min_target_pts (min_target_pts),
        .assert_cnt     (assert_cnt),
        .clear_cnt      (clear_cnt),
        .zone_rden      (zone_rden),
        .zone_rdaddr    (zone_rdaddr),
        .zone_rddata    (zone_rddata),
        .alarm_io       (alarm_io),
        .scan_done      (scan_done),
        .scan_overrun   (scan_overrun)
    );

    // Boundary RAM: same boundary at every address, one-cycle read latency.
    always @(posedge clk) begin
        if (zone_rden) begin
            zone_rddata <= bnd;
            nreads      <= nreads + 1;
            last_addr   <= int'(zone_rdaddr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_scan();
        cycle_enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic smp(input logic [15:0] pos);
        target_valid = 1'b1;
        target_pos   = pos;
        @(negedge clk);
        target_valid = 1'b0;
        last_rd      = zone_rdaddr;
        @(negedge clk);
    endtask

    // Optionally presents a sample in the same cycle the fall is detected.
    task automatic end_scan(input bit with_smp, input logic [15:0] pos);
        cycle_enable = 1'b0;
        @(negedge clk);
        if (with_smp) begin
            target_valid = 1'b1;
            target_pos   = pos;
        end
        @(negedge clk);
        target_valid = 1'b0;
        @(negedge clk);
        chk("scan_done_pulse", {31'b0, scan_done}, 32'd1);
        @(negedge clk);
        chk("scan_done_low", {31'b0, scan_done}, 32'd0);
        @(negedge clk);
    endtask

    task automatic scan_n(input int n, input logic [15:0] pos);
        start_scan();
        for (int i = 0; i < n; i++) smp(pos);
        end_scan(1'b0, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; hw_type = 2'd0; cycle_enable = 1'b0; target_valid = 1'b0;
        target_pos = '0; min_target_pts = 8'd3; assert_cnt = 4'd1; clear_cnt = 4'd1;
        zone_rddata = '0;
        bnd = {16'd500, 16'd500, 16'd500};
        repeat (3) @(negedge clk);
        chk("rst_alarm_io", {29'b0, alarm_io}, 32'd0);
        chk("rst_scan_done", {31'b0, scan_done}, 32'd0);
        chk("rst_overrun", {31'b0, scan_overrun}, 32'd0);
        chk("rst_rden", {31'b0, zone_rden}, 32'd0);
        chk("rst_rdaddr", {22'b0, zone_rdaddr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Five hits inside 500 on all zones
        start_scan();
        for (int i = 0; i < 5; i++) smp(16'd400);
        chk("first_addrs", {22'b0, last_rd}, 32'd4);
        chk("no_alarm_before_finish", {29'b0, alarm_io}, 32'd0);
        end_scan(1'b0, 16'd0);
        chk("alarm_all_npn", {29'b0, alarm_io}, 32'b111);
        hw_type = 2'd1;
        repeat (2) @(negedge clk);
        chk("alarm_all_pnp", {29'b0, alarm_io}, 32'b000);
        hw_type = 2'd0;
        repeat (2) @(negedge clk);
        scan_n(5, 16'd600);
        chk("miss_clears", {29'b0, alarm_io}, 32'd0);

        // Disabled zone 1 and zero-distance samples
        bnd = {16'd500, 16'hFFFF, 16'd500};
        scan_n(5, 16'd10);
        chk("zone1_disabled", {29'b0, alarm_io}, 32'b101);
        scan_n(5, 16'd600);
        bnd = {16'd500, 16'd500, 16'd500};
        scan_n(5, 16'd0);
        chk("pos_zero_no_hit", {29'b0, alarm_io}, 32'd0);

        // Run length: isolated vs contiguous hits
        start_scan();
        smp(16'd400); smp(16'd600); smp(16'd400); smp(16'd600); smp(16'd600);
        end_scan(1'b0, 16'd0);
        chk("isolated_hits", {29'b0, alarm_io}, 32'd0);
        start_scan();
        smp(16'd400); smp(16'd400); smp(16'd400); smp(16'd600);
        end_scan(1'b0, 16'd0);
        chk("contig_hits", {29'b0, alarm_io}, 32'b111);
        scan_n(3, 16'd600);

        // Distance equal to boundary hits, one beyond misses
        scan_n(3, 16'd500);
        chk("pos_eq_bound", {29'b0, alarm_io}, 32'b111);
        scan_n(3, 16'd501);
        chk("pos_gt_bound", {29'b0, alarm_io}, 32'd0);

        // Fall coinciding with a sample discards that sample
        start_scan();
        smp(16'd400); smp(16'd400);
        end_scan(1'b1, 16'd400);
        chk("fall_wins", {29'b0, alarm_io}, 32'd0);

        // min_target_pts of zero acts as one
        min_target_pts = 8'd0;
        scan_n(1, 16'd400);
        chk("min_pts_zero", {29'b0, alarm_io}, 32'b111);
        scan_n(1, 16'd600);
        min_target_pts = 8'd3;

        // Scan hysteresis
        assert_cnt = 4'd3; clear_cnt = 4'd2;
        scan_n(3, 16'd400);
        chk("hyst_hit1", {29'b0, alarm_io}, 32'd0);
        scan_n(3, 16'd400);
        chk("hyst_hit2", {29'b0, alarm_io}, 32'd0);
        scan_n(3, 16'd400);
        chk("hyst_hit3", {29'b0, alarm_io}, 32'b111);
        scan_n(3, 16'd600);
        chk("hyst_miss1", {29'b0, alarm_io}, 32'b111);
        scan_n(3, 16'd600);
        chk("hyst_miss2", {29'b0, alarm_io}, 32'd0);
        assert_cnt = 4'd1; clear_cnt = 4'd1;

        // Overrun: back-to-back valid drops the second sample
        start_scan();
        chk("overrun_clear0", {31'b0, scan_overrun}, 32'd0);
        target_valid = 1'b1; target_pos = 16'd400;
        repeat (2) @(negedge clk);
        target_valid = 1'b0;
        @(negedge clk);
        chk("overrun_set", {31'b0, scan_overrun}, 32'd1);
        smp(16'd400);
        chk("overrun_addr", {22'b0, last_rd}, 32'd1);
        end_scan(1'b0, 16'd0);
        chk("overrun_sticky", {31'b0, scan_overrun}, 32'd1);
        chk("overrun_dropped_hit", {29'b0, alarm_io}, 32'd0);
        start_scan();
        chk("overrun_cleared", {31'b0, scan_overrun}, 32'd0);
        end_scan(1'b0, 16'd0);

        // Reset mid-scan with an alarm raised
        scan_n(3, 16'd400);
        chk("pre_reset_alarm", {29'b0, alarm_io}, 32'b111);
        start_scan();
        smp(16'd400);
        rst_n = 1'b0; cycle_enable = 1'b0;
        #1;
        chk("reset_alarm_now", {29'b0, alarm_io}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_alarm", {29'b0, alarm_io}, 32'd0);
        chk("post_reset_done", {31'b0, scan_done}, 32'd0);

        // More samples than points: reads stop at the last address
        n0 = nreads;
        start_scan();
        for (int i = 0; i < 900; i++) smp(16'd400);
        end_scan(1'b0, 16'd0);
        chk("read_count", 32'(nreads - n0), 32'd811);
        chk("last_addr", 32'(last_addr), 32'd810);
        chk("long_scan_alarm", {29'b0, alarm_io}, 32'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zone_alarm_engine.md
ZONE_ALARM_ENGINE -- requirements
Module: zone_alarm_engine

Interface
REQ-001 SHALL have parameter NZONE, default 3, number of independent alarm zones.
REQ-002 SHALL have parameter NPOINT, default 811, number of angular points per scan.
REQ-003 SHALL have parameter DW, default 16, distance and boundary width.
REQ-004 SHALL have parameter AW, default 10, boundary RAM address width.
REQ-005 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port hw_type, input, 2, output polarity select; 1 means PNP, which inverts the output.
REQ-008 SHALL have port cycle_enable, input, 1, level high for the duration of one scan.
REQ-009 SHALL have port target_valid, input, 1, one-cycle pulse qualifying target_pos.
REQ-010 SHALL have port target_pos, input, DW, measured distance; 0 means no echo.
REQ-011 SHALL have port min_target_pts, input, 8, minimum consecutive hit points that count as an object.
REQ-012 SHALL have ports assert_cnt and clear_cnt, input, 4 each, scan counts needed to raise and to drop an alarm.
REQ-013 SHALL have ports zone_rden, output, 1, and zone_rdaddr, output, AW, boundary RAM read.
REQ-014 SHALL have port zone_rddata, input, NZONE*DW, boundaries for all zones, valid 1 cycle after zone_rden.
REQ-015 SHALL have port alarm_io, output, NZONE, registered polarity-adjusted alarms.
REQ-016 SHALL have ports scan_done, output, 1, pulse after the scan-end update, and scan_overrun, output, 1, sticky error flag.

Function
REQ-017 The FSM SHALL have states IDLE, ARM, READ, CMP and FINISH; it SHALL be one-hot and reset to IDLE.
REQ-018 IDLE→ARM on a cycle_enable rising edge (2-stage edge detect); ARM SHALL clear pt_idx, run lengths and per-scan hit flags.
REQ-019 ARM/CMP→READ on target_valid: latch target_pos, assert zone_rden one cycle with zone_rdaddr=pt_idx.
REQ-020 READ→CMP unconditionally; in CMP, compare each zone, then increment pt_idx.
REQ-021 A point SHALL hit zone z iff boundary≠all-ones, target_pos≠0 and target_pos≤boundary.
REQ-022 Per zone run SHALL increment (saturating at 255) on a hit and reset to 0 on a miss; the zone scan-hit flag SHALL be set when run≥max(min_target_pts,1).
REQ-023 target_valid in READ SHALL drop the sample and set scan_overrun; scan_overrun SHALL clear in ARM.
REQ-024 Samples with pt_idx≥NPOINT SHALL be ignored, with no RAM read and no pt_idx wrap.
REQ-025 On cycle_enable falling edge (any non-IDLE state) → FINISH, then update each zone for one cycle and return to IDLE.
REQ-026 Scan update for a hit scan: hit_streak++ (saturating at 15), clear_streak=0; alarm sets when hit_streak≥max(assert_cnt,1).
REQ-027 Scan update for a miss scan: clear_streak++ (saturating at 15), hit_streak=0; alarm clears when clear_streak≥max(clear_cnt,1).
REQ-028 scan_done SHALL pulse for 1 cycle, the cycle after FINISH.
REQ-029 alarm_io SHALL equal ~alarm_r when hw_type==1, else alarm_r, registered (1-cycle latency).
REQ-030 Simultaneous cycle_enable fall and target_valid: the fall SHALL win and the sample SHALL be discarded.

Reset
REQ-031 rst_n low SHALL force state IDLE and set pt_idx, runs, streaks, alarm_r, scan_done, scan_overrun, zone_rden, zone_rdaddr and alarm_io to 0.
REQ-032 Reset asserted mid-scan SHALL abandon the scan; the next scan starts only on a fresh rising edge.

Configuration
REQ-033 Macro ZONE_FAST_ALARM_EN defined: alarm_r[z] SHALL set in the cycle after the scan-hit flag sets when assert_cnt≤1, without waiting for FINISH; clearing remains at FINISH.
REQ-034 Macro undefined: alarm changes SHALL occur only at FINISH.

Structure
REQ-035 Package zone_alarm_pkg SHALL hold the state encoding, BOUND_DISABLED (all-ones), RUN_MAX=255 and STREAK_MAX=15.
REQ-036 Per-zone run and streak logic SHALL be sub-module zone_tracker, generated NZONE times.

Verification
REQ-037 Boundary 500 on all zones, 5 consecutive pos=400, min_target_pts=3, assert_cnt=1 → alarm_io=3'b111 after FINISH+1; with hw_type=1 → 3'b000.
REQ-038 Zone1 boundary 0xFFFF, pos=10 → zone1 never alarms; pos=0 on all zones → no alarm.
REQ-039 Hits at 2 isolated points, min_target_pts=3 → no alarm; 3 contiguous hit points → alarm.
REQ-040 assert_cnt=3, clear_cnt=2: hit scans 1 and 2 → no alarm, hit scan 3 → alarm; miss scan 1 → alarm held, miss scan 2 → cleared.
REQ-041 Back-to-back target_valid → scan_overrun=1, pt_idx advanced once; next rising edge clears it.
REQ-042 rst_n low mid-scan with alarm set → alarm_io=0 immediately; 900 samples → reads stop at address 810.
